// File: rtl/multi_issue_ctrl_if.sv
// Decode-stage issue bundle: head-of-FIFO decode fields in, per-lane issue
// mask, pop count and delay-slot flags out.
interface multi_issue_ctrl_if #(
  parameter int ISSUE_W = 2,
  parameter int LAT_W   = 2,
  parameter int CNT_W   = 2
);
  logic                          stall;
  logic                          flush;
  logic [CNT_W-1:0]              avail;
  logic [ISSUE_W-1:0][4:0]       rs;
  logic [ISSUE_W-1:0][4:0]       rt;
  logic [ISSUE_W-1:0]            read_rs;
  logic [ISSUE_W-1:0]            read_rt;
  logic [ISSUE_W-1:0]            reg_wen;
  logic [ISSUE_W-1:0][4:0]       waddr;
  logic [ISSUE_W-1:0][LAT_W-1:0] lat;
  logic [ISSUE_W-1:0]            hilo_wr;
  logic [ISSUE_W-1:0]            hilo_rd;
  logic [ISSUE_W-1:0]            cp0_wr;
  logic [ISSUE_W-1:0]            cp0_rd;
  logic [ISSUE_W-1:0]            is_mem;
  logic [ISSUE_W-1:0]            is_mdu;
  logic [ISSUE_W-1:0]            is_branch;
  logic [ISSUE_W-1:0]            only_one_issue;
  logic [ISSUE_W-1:0]            may_bring_flush;
  logic [ISSUE_W-1:0]            lane_ena;
  logic [CNT_W-1:0]              issue_cnt;
  logic [ISSUE_W-1:0]            in_delayslot;

  modport master (
    output stall, flush, avail, rs, rt, read_rs, read_rt, reg_wen, waddr, lat,
           hilo_wr, hilo_rd, cp0_wr, cp0_rd, is_mem, is_mdu, is_branch,
           only_one_issue, may_bring_flush,
    input  lane_ena, issue_cnt, in_delayslot
  );

  modport slave (
    input  stall, flush, avail, rs, rt, read_rs, read_rt, reg_wen, waddr, lat,
           hilo_wr, hilo_rd, cp0_wr, cp0_rd, is_mem, is_mdu, is_branch,
           only_one_issue, may_bring_flush,
    output lane_ena, issue_cnt, in_delayslot
  );
endinterface

// File: rtl/multi_issue_ctrl.sv
// N-lane in-order issue controller: prefix issue mask from intra-group hazards,
// a per-GPR latency scoreboard and a registered branch delay-slot tracker.
module multi_issue_ctrl #(
  parameter int ISSUE_W = 2,
  parameter int MAX_LAT = 3,
  parameter int LAT_W   = $clog2(MAX_LAT + 1),
  parameter int CNT_W   = $clog2(ISSUE_W + 1)
) (
  input logic               clk,
  input logic               rst,
  multi_issue_ctrl_if.slave bus
);

  logic [31:0]        busy;
  logic [ISSUE_W-1:0] lane_block;
  logic [ISSUE_W-1:0] lane_ena;
  logic [ISSUE_W-1:0] in_ds;
  logic [CNT_W-1:0]   issue_cnt;
  logic               last_branch;
  logic               ds_pending_reg;
  logic               ds_pending_next;

  genvar gi;

  // One countdown per GPR; a nonzero count means the result is not yet forwardable.
  generate
    for (gi = 0; gi < 32; gi++) begin : g_sb
      logic [LAT_W-1:0] cnt_reg;
      logic [LAT_W-1:0] cnt_next;

      always_comb begin
        cnt_next = (cnt_reg != '0) ? cnt_reg - LAT_W'(1) : '0;
        for (int j = 0; j < ISSUE_W; j++) begin
          if (lane_ena[j] && bus.reg_wen[j] && bus.waddr[j] != 5'd0 &&
              bus.waddr[j] == 5'(gi))
            cnt_next = bus.lat[j];
        end
      end

      always_ff @(posedge clk) begin
        if (rst)
          cnt_reg <= '0;
        else if (!bus.stall)
          cnt_reg <= cnt_next;
      end

      assign busy[gi] = (cnt_reg != '0);
    end
  endgenerate

  // Per-lane block: scoreboard hit, plus pairing rules against every older lane.
  generate
    for (gi = 0; gi < ISSUE_W; gi++) begin : g_lane
      logic hz;

      always_comb begin
        hz = (bus.read_rs[gi] && busy[bus.rs[gi]]) ||
             (bus.read_rt[gi] && busy[bus.rt[gi]]);
        if (gi != 0)
          hz = hz || bus.only_one_issue[gi] || bus.may_bring_flush[gi];
        for (int j = 0; j < gi; j++) begin
          if (bus.reg_wen[j] && bus.waddr[j] != 5'd0 &&
              ((bus.read_rs[gi] && bus.rs[gi] == bus.waddr[j]) ||
               (bus.read_rt[gi] && bus.rt[gi] == bus.waddr[j])))
            hz = 1'b1;
          if (bus.hilo_wr[j] && (bus.hilo_rd[gi] || bus.hilo_wr[gi]))
            hz = 1'b1;
          if (bus.cp0_wr[j] && bus.cp0_rd[gi])
            hz = 1'b1;
          if ((bus.is_mem[j] && bus.is_mem[gi]) || (bus.is_mdu[j] && bus.is_mdu[gi]))
            hz = 1'b1;
          if (bus.only_one_issue[j])
            hz = 1'b1;
          if (bus.is_branch[j] && (j + 1 != gi))
            hz = 1'b1;
        end
      end

      assign lane_block[gi] = hz;
    end
  endgenerate

  always_comb begin
    lane_ena = '0;
    if (!rst && !bus.stall && !bus.flush) begin
      lane_ena[0] = (bus.avail != '0) && !lane_block[0];
      for (int i = 1; i < ISSUE_W; i++)
        lane_ena[i] = lane_ena[i-1] && (int'(bus.avail) > i) &&
                      !ds_pending_reg && !lane_block[i];
    end
  end

  always_comb begin
    issue_cnt = '0;
    for (int i = 0; i < ISSUE_W; i++)
      if (lane_ena[i])
        issue_cnt = issue_cnt + CNT_W'(1);
  end

  // The last issued lane is the one whose successor did not issue.
  assign last_branch = |(lane_ena & ~(lane_ena >> 1) & bus.is_branch);

  assign in_ds[0] = lane_ena[0] & ds_pending_reg;
  generate
    for (gi = 1; gi < ISSUE_W; gi++) begin : g_ds
      assign in_ds[gi] = lane_ena[gi] & bus.is_branch[gi-1];
    end
  endgenerate

  always_comb begin
    ds_pending_next = ds_pending_reg;
    if (bus.flush)
      ds_pending_next = 1'b0;
    else if (last_branch)
      ds_pending_next = 1'b1;
    else if (lane_ena[0] && ds_pending_reg)
      ds_pending_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      ds_pending_reg <= 1'b0;
    else
      ds_pending_reg <= ds_pending_next;
  end

  assign bus.lane_ena     = lane_ena;
  assign bus.issue_cnt    = issue_cnt;
  assign bus.in_delayslot = in_ds;

endmodule

// File: tb/tb_multi_issue_ctrl.sv
// Self-checking bench: directed issue scenarios plus randomized groups checked
// against a rule-level model (per-register remaining-busy cycles, delay-slot flag).
module tb_multi_issue_ctrl;
  localparam int ISSUE_W = 4;
  localparam int MAX_LAT = 3;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);
  localparam int CNT_W   = $clog2(ISSUE_W + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_issue_ctrl_if #(.ISSUE_W(ISSUE_W), .LAT_W(LAT_W), .CNT_W(CNT_W)) bus ();

  multi_issue_ctrl #(.ISSUE_W(ISSUE_W), .MAX_LAT(MAX_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int rem [32];
  bit ds_m;
  int exp_n;
  logic [ISSUE_W-1:0] exp_ena;
  logic [ISSUE_W-1:0] exp_ids;
  int checks = 0;
  int errors = 0;
  int txn = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit src_busy(input int i);
    return (bus.read_rs[i] && bus.rs[i] != 5'd0 && rem[bus.rs[i]] > 0) ||
           (bus.read_rt[i] && bus.rt[i] != 5'd0 && rem[bus.rt[i]] > 0);
  endfunction

  // Can lane i join the group made of lanes 0..i-1?
  function automatic bit may_join(input int i);
    int nmem = 0;
    int nmdu = 0;
    if (src_busy(i)) return 1'b0;
    if (i == 0) return 1'b1;
    if (ds_m || bus.may_bring_flush[i]) return 1'b0;
    for (int j = 0; j <= i; j++) begin
      if (bus.only_one_issue[j]) return 1'b0;
      nmem += int'(bus.is_mem[j]);
      nmdu += int'(bus.is_mdu[j]);
    end
    if (nmem > 1 || nmdu > 1) return 1'b0;
    for (int j = 0; j < i; j++) begin
      if (bus.reg_wen[j] && bus.waddr[j] != 5'd0 &&
          ((bus.read_rs[i] && bus.rs[i] == bus.waddr[j]) ||
           (bus.read_rt[i] && bus.rt[i] == bus.waddr[j]))) return 1'b0;
      if (bus.hilo_wr[j] && (bus.hilo_rd[i] || bus.hilo_wr[i])) return 1'b0;
      if (bus.cp0_wr[j] && bus.cp0_rd[i]) return 1'b0;
      if (bus.is_branch[j] && i != j + 1) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_eval();
    exp_n = 0;
    if (!rst && !bus.stall && !bus.flush) begin
      for (int i = 0; i < int'(bus.avail) && i < ISSUE_W; i++) begin
        if (!may_join(i)) break;
        exp_n++;
      end
    end
    exp_ena = '0;
    exp_ids = '0;
    for (int i = 0; i < exp_n; i++) begin
      exp_ena[i] = 1'b1;
      exp_ids[i] = (i == 0) ? ds_m : bus.is_branch[i-1];
    end
  endtask

  task automatic commit();
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) rem[r] = 0;
      ds_m = 1'b0;
    end else begin
      if (!bus.stall) begin
        for (int r = 0; r < 32; r++) if (rem[r] > 0) rem[r]--;
        for (int i = 0; i < exp_n; i++)
          if (bus.reg_wen[i] && bus.waddr[i] != 5'd0) rem[bus.waddr[i]] = int'(bus.lat[i]);
      end
      if (bus.flush) ds_m = 1'b0;
      else if (exp_n > 0 && bus.is_branch[exp_n-1]) ds_m = 1'b1;
      else if (exp_n > 0 && ds_m) ds_m = 1'b0;
    end
  endtask

  task automatic settle(input string tag);
    #1;
    model_eval();
    txn++;
    $display("txn %0d %s rst=%b avail=%0d stall=%b flush=%b ena=%b cnt=%0d ids=%b",
             txn, tag, rst, bus.avail, bus.stall, bus.flush, bus.lane_ena,
             bus.issue_cnt, bus.in_delayslot);
    check({tag, "_ena"}, 32'(bus.lane_ena), 32'(exp_ena));
    check({tag, "_cnt"}, 32'(bus.issue_cnt), 32'(exp_n));
    check({tag, "_ids"}, 32'(bus.in_delayslot), 32'(exp_ids));
  endtask

  task automatic next_txn();
    @(negedge clk);
    bus.stall = 1'b0;  bus.flush = 1'b0;  bus.avail = '0;
    bus.rs = '0;  bus.rt = '0;  bus.waddr = '0;  bus.lat = '0;
    bus.read_rs = '0;  bus.read_rt = '0;  bus.reg_wen = '0;
    bus.hilo_wr = '0;  bus.hilo_rd = '0;  bus.cp0_wr = '0;  bus.cp0_rd = '0;
    bus.is_mem = '0;  bus.is_mdu = '0;  bus.is_branch = '0;
    bus.only_one_issue = '0;  bus.may_bring_flush = '0;
  endtask

  task automatic lane(input int l, input int d, input int s, input int t, input int latv);
    bus.reg_wen[l] = (d != 0);
    bus.waddr[l]   = 5'(d);
    bus.rs[l]      = 5'(s);
    bus.rt[l]      = 5'(t);
    bus.read_rs[l] = (s != 0);
    bus.read_rt[l] = (t != 0);
    bus.lat[l]     = LAT_W'(latv);
  endtask

  task automatic randomize_inputs();
    bus.avail = CNT_W'($urandom_range(0, ISSUE_W));
    bus.stall = ($urandom_range(0, 7) == 0);
    bus.flush = ($urandom_range(0, 15) == 0);
    rst       = ($urandom_range(0, 63) == 0);
    for (int l = 0; l < ISSUE_W; l++) begin
      bus.rs[l]              = 5'($urandom_range(0, 7));
      bus.rt[l]              = 5'($urandom_range(0, 7));
      bus.waddr[l]           = 5'($urandom_range(0, 7));
      bus.lat[l]             = LAT_W'($urandom_range(0, MAX_LAT));
      bus.read_rs[l]         = $urandom_range(0, 1) == 1;
      bus.read_rt[l]         = $urandom_range(0, 1) == 1;
      bus.reg_wen[l]         = $urandom_range(0, 1) == 1;
      bus.hilo_wr[l]         = $urandom_range(0, 7) == 0;
      bus.hilo_rd[l]         = $urandom_range(0, 7) == 0;
      bus.cp0_wr[l]          = $urandom_range(0, 7) == 0;
      bus.cp0_rd[l]          = $urandom_range(0, 7) == 0;
      bus.is_mem[l]          = $urandom_range(0, 3) == 0;
      bus.is_mdu[l]          = $urandom_range(0, 6) == 0;
      bus.is_branch[l]       = $urandom_range(0, 7) == 0;
      bus.only_one_issue[l]  = $urandom_range(0, 11) == 0;
      bus.may_bring_flush[l] = $urandom_range(0, 11) == 0;
    end
  endtask

  initial begin
    rst = 1'b1;
    ds_m = 1'b0;
    for (int r = 0; r < 32; r++) rem[r] = 0;

    // Reset holds every output low even with issuable work present.
    repeat (2) begin
      next_txn(); bus.avail = 2; lane(0, 1, 2, 3, 0); lane(1, 4, 2, 3, 0);
      settle("rst"); check("rst_ena0", 32'(bus.lane_ena), 32'h0); commit();
    end
    rst = 1'b0;

    next_txn(); bus.avail = 2; lane(0, 1, 2, 3, 0); lane(1, 4, 2, 3, 0);
    settle("dual"); check("dual_lit", 32'(bus.lane_ena), 32'h3);
    check("dual_cnt_lit", 32'(bus.issue_cnt), 32'd2); commit();

    next_txn(); bus.avail = 2; lane(0, 5, 2, 0, 0); lane(1, 6, 5, 0, 0);
    settle("raw"); check("raw_lit", 32'(bus.lane_ena), 32'h1); commit();
    next_txn(); bus.avail = 1; lane(0, 6, 5, 0, 0);
    settle("raw_next"); check("raw_next_lit", 32'(bus.lane_ena), 32'h1); commit();

    next_txn(); bus.avail = 1; lane(0, 7, 2, 0, 1); bus.is_mem[0] = 1'b1;
    settle("ld"); commit();
    next_txn(); bus.avail = 1; lane(0, 8, 7, 0, 0);
    settle("ld_use1"); check("ld_use1_lit", 32'(bus.lane_ena), 32'h0); commit();
    next_txn(); bus.avail = 1; lane(0, 8, 7, 0, 0);
    settle("ld_use2"); check("ld_use2_lit", 32'(bus.lane_ena), 32'h1); commit();

    next_txn(); bus.avail = 1; lane(0, 7, 2, 0, 1); bus.is_mem[0] = 1'b1;
    settle("lds"); commit();
    next_txn(); bus.avail = 1; lane(0, 8, 7, 0, 0); bus.stall = 1'b1;
    settle("lds_stall"); commit();
    next_txn(); bus.avail = 1; lane(0, 8, 7, 0, 0);
    settle("lds_use2"); check("lds_use2_lit", 32'(bus.lane_ena), 32'h0); commit();
    next_txn(); bus.avail = 1; lane(0, 8, 7, 0, 0);
    settle("lds_use3"); check("lds_use3_lit", 32'(bus.lane_ena), 32'h1); commit();

    next_txn(); bus.avail = 2; lane(0, 10, 2, 0, 0); lane(1, 0, 2, 0, 0); bus.is_branch[1] = 1'b1;
    settle("br"); check("br_lit", 32'(bus.lane_ena), 32'h3); commit();
    next_txn(); bus.avail = 2; lane(0, 11, 2, 0, 0); lane(1, 12, 2, 0, 0);
    settle("br_slot"); check("br_slot_lit", 32'(bus.lane_ena), 32'h1);
    check("br_slot_ids_lit", 32'(bus.in_delayslot), 32'h1); commit();
    next_txn(); bus.avail = 2; lane(0, 11, 2, 0, 0); lane(1, 12, 2, 0, 0);
    settle("br_after"); check("br_after_lit", 32'(bus.lane_ena), 32'h3); commit();

    next_txn(); bus.avail = 2; lane(0, 10, 2, 0, 0); lane(1, 0, 2, 0, 0); bus.is_branch[1] = 1'b1;
    settle("brf"); commit();
    next_txn(); bus.avail = 2; lane(0, 11, 2, 0, 0); lane(1, 12, 2, 0, 0); bus.flush = 1'b1;
    settle("brf_flush"); check("brf_flush_lit", 32'(bus.lane_ena), 32'h0); commit();
    next_txn(); bus.avail = 2; lane(0, 11, 2, 0, 0); lane(1, 12, 2, 0, 0);
    settle("brf_after"); check("brf_after_lit", 32'(bus.lane_ena), 32'h3);
    check("brf_after_ids_lit", 32'(bus.in_delayslot), 32'h0); commit();

    next_txn(); bus.avail = 4; lane(0, 1, 2, 0, 0); lane(1, 13, 2, 0, 1); lane(2, 14, 3, 0, 1);
    lane(3, 15, 2, 0, 0); bus.is_mem[1] = 1'b1; bus.is_mem[2] = 1'b1;
    settle("mem2"); check("mem2_lit", 32'(bus.lane_ena), 32'h3); commit();

    next_txn(); bus.avail = 2; lane(0, 9, 2, 0, 3); lane(1, 9, 3, 0, 1);
    settle("waw"); check("waw_lit", 32'(bus.lane_ena), 32'h3); commit();
    next_txn(); bus.avail = 1; lane(0, 16, 9, 0, 0);
    settle("waw_use1"); check("waw_use1_lit", 32'(bus.lane_ena), 32'h0); commit();
    next_txn(); bus.avail = 1; lane(0, 16, 9, 0, 0);
    settle("waw_use2"); check("waw_use2_lit", 32'(bus.lane_ena), 32'h1); commit();

    for (int n = 0; n < 300; n++) begin
      next_txn();
      randomize_inputs();
      settle("rnd");
      commit();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
